// File: rtl/obi_interconnect.sv
// OBI crossbar: N masters to M always-ready slaves, one arbiter per slave port.
// Optional OBI_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module obi_interconnect #(
  parameter int unsigned MASTERS = 3,
  parameter int unsigned SLAVES  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MASTERS-1:0]   master_req_i,
  output logic [MASTERS-1:0]   master_gnt_o,
  output logic [MASTERS-1:0]   master_rvalid_o,
  input  logic [MASTERS-1:0]   master_we_i,
  input  logic [3:0]           master_be_i       [MASTERS],
  input  logic [31:0]          master_addr_i     [MASTERS],
  input  logic [31:0]          master_wdata_i    [MASTERS],
  output logic [31:0]          master_rdata_o    [MASTERS],
  input  logic [31:0]          slave_addr_mask_i [SLAVES],
  input  logic [31:0]          slave_addr_base_i [SLAVES],
  output logic [SLAVES-1:0]    slave_req_o,
  input  logic [SLAVES-1:0]    slave_gnt_i,
  input  logic [SLAVES-1:0]    slave_rvalid_i,
  output logic [SLAVES-1:0]    slave_we_o,
  output logic [3:0]           slave_be_o        [SLAVES],
  output logic [31:0]          slave_addr_o      [SLAVES],
  output logic [31:0]          slave_wdata_o     [SLAVES],
  input  logic [31:0]          slave_rdata_i     [SLAVES]
);

  localparam int unsigned MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  // Target encoding: 0..SLAVES-1 is a slave, SLAVES means unmapped.
  localparam int unsigned TW = $clog2(SLAVES + 1);

  logic [TW-1:0]     tgt      [MASTERS];
  logic [SLAVES-1:0] sel_vld;
  logic [MW-1:0]     sel_idx  [SLAVES];
  logic [MASTERS-1:0] rvalid_q;
  logic [TW-1:0]     tgt_q    [MASTERS];

  // Slaves are always ready; their handshake outputs carry no information.
  logic unused_slave_rsp;
  assign unused_slave_rsp = ^{slave_gnt_i, slave_rvalid_i};

  // Address decode; walking slaves from highest to lowest lets the lowest match win.
  always_comb begin
    for (int unsigned m = 0; m < MASTERS; m++) begin
      tgt[m] = TW'(SLAVES);
      for (int unsigned k = 0; k < SLAVES; k++) begin
        if ((master_addr_i[m] & slave_addr_mask_i[SLAVES-1-k]) == slave_addr_base_i[SLAVES-1-k])
          tgt[m] = TW'(SLAVES - 1 - k);
      end
    end
  end

`ifdef OBI_RR_ARB_EN
  logic [MW-1:0] last_q [SLAVES];

  // Two passes: masters above the last winner first, then wrap to the rest.
  always_comb begin
    sel_vld = '0;
    for (int unsigned s = 0; s < SLAVES; s++) begin
      sel_idx[s] = '0;
      for (int unsigned m = 0; m < MASTERS; m++) begin
        if (!sel_vld[s] && master_req_i[m] && tgt[m] == TW'(s) && MW'(m) > last_q[s]) begin
          sel_vld[s] = 1'b1;
          sel_idx[s] = MW'(m);
        end
      end
      for (int unsigned m = 0; m < MASTERS; m++) begin
        if (!sel_vld[s] && master_req_i[m] && tgt[m] == TW'(s)) begin
          sel_vld[s] = 1'b1;
          sel_idx[s] = MW'(m);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SLAVES; s++) last_q[s] <= MW'(MASTERS - 1);
    end else begin
      for (int unsigned s = 0; s < SLAVES; s++) begin
        if (sel_vld[s]) last_q[s] <= sel_idx[s];
      end
    end
  end
`else
  always_comb begin
    sel_vld = '0;
    for (int unsigned s = 0; s < SLAVES; s++) begin
      sel_idx[s] = '0;
      for (int unsigned m = 0; m < MASTERS; m++) begin
        if (!sel_vld[s] && master_req_i[m] && tgt[m] == TW'(s)) begin
          sel_vld[s] = 1'b1;
          sel_idx[s] = MW'(m);
        end
      end
    end
  end
`endif

  // Unmapped requests are granted at once and answered with zero data.
  always_comb begin
    master_gnt_o = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      if (master_req_i[m] && tgt[m] == TW'(SLAVES)) master_gnt_o[m] = 1'b1;
      for (int unsigned s = 0; s < SLAVES; s++) begin
        if (sel_vld[s] && sel_idx[s] == MW'(m)) master_gnt_o[m] = 1'b1;
      end
    end
  end

  always_comb begin
    slave_req_o = '0;
    slave_we_o  = '0;
    for (int unsigned s = 0; s < SLAVES; s++) begin
      slave_be_o[s]    = '0;
      slave_addr_o[s]  = '0;
      slave_wdata_o[s] = '0;
      for (int unsigned m = 0; m < MASTERS; m++) begin
        if (sel_vld[s] && sel_idx[s] == MW'(m)) begin
          slave_req_o[s]   = 1'b1;
          slave_we_o[s]    = master_we_i[m];
          slave_be_o[s]    = master_be_i[m];
          slave_addr_o[s]  = master_addr_i[m];
          slave_wdata_o[s] = master_wdata_i[m];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      for (int unsigned m = 0; m < MASTERS; m++) tgt_q[m] <= '0;
    end else begin
      rvalid_q <= master_gnt_o;
      for (int unsigned m = 0; m < MASTERS; m++) begin
        if (master_gnt_o[m]) tgt_q[m] <= tgt[m];
      end
    end
  end

  assign master_rvalid_o = rvalid_q;

  always_comb begin
    for (int unsigned m = 0; m < MASTERS; m++) begin
      master_rdata_o[m] = '0;
      if (rvalid_q[m]) begin
        for (int unsigned s = 0; s < SLAVES; s++) begin
          if (tgt_q[m] == TW'(s)) master_rdata_o[m] = slave_rdata_i[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_obi_interconnect.sv
// Directed bench for obi_interconnect: decode, arbitration, unmapped, reset, overlap.
module tb_obi_interconnect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  we = '0;
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [31:0] smask [3];
  logic [31:0] sbase [3];
  logic [2:0]  sreq;
  logic [2:0]  sgnt = '0;
  logic [2:0]  srv = '0;
  logic [2:0]  swe;
  logic [3:0]  sbe    [3];
  logic [31:0] saddr  [3];
  logic [31:0] swdata [3];
  logic [31:0] srdata [3];

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_g [3];

  always #5 clk = ~clk;

  obi_interconnect #(.MASTERS(3), .SLAVES(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .master_req_i(req), .master_gnt_o(gnt), .master_rvalid_o(rvalid),
    .master_we_i(we), .master_be_i(be), .master_addr_i(addr),
    .master_wdata_i(wdata), .master_rdata_o(rdata),
    .slave_addr_mask_i(smask), .slave_addr_base_i(sbase),
    .slave_req_o(sreq), .slave_gnt_i(sgnt), .slave_rvalid_i(srv),
    .slave_we_o(swe), .slave_be_o(sbe), .slave_addr_o(saddr),
    .slave_wdata_o(swdata), .slave_rdata_i(srdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      be[i] = 4'hF; addr[i] = '0; wdata[i] = '0;
    end
    smask[0] = 32'hF000_0000; sbase[0] = 32'h0000_0000;
    smask[1] = 32'hF000_0000; sbase[1] = 32'h1000_0000;
    smask[2] = 32'hFF00_0000; sbase[2] = 32'h1000_0000;
    srdata[0] = 32'hDEAD_BEEF; srdata[1] = 32'hCAFE_0001; srdata[2] = 32'h0BAD_0002;

    // Reset state
    step(); step();
    chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rst_rdata2", rdata[2], 32'd0);
    chk("rst_sreq", {29'd0, sreq}, 32'd0);
    #4 rst = 1'b0;

    // Single read: master 2 -> slave 0
    step();
    req = 3'b100; addr[2] = 32'h0000_0010; we = '0;
    #1;
    chk("rd_gnt", {29'd0, gnt}, 32'h4);
    chk("rd_sreq", {29'd0, sreq}, 32'h1);
    chk("rd_saddr0", saddr[0], 32'h0000_0010);
    step();
    req = '0;
    #1;
    chk("rd_rvalid", {29'd0, rvalid}, 32'h4);
    chk("rd_rdata2", rdata[2], 32'hDEAD_BEEF);
    chk("rd_rdata0_idle", rdata[0], 32'd0);
    step();
    chk("rd_rvalid_off", {29'd0, rvalid}, 32'd0);

    // Parallel: master 0 writes slave 1 while master 2 reads slave 0
    req = 3'b101; we = 3'b001;
    addr[0] = 32'h1000_0004; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
    addr[2] = 32'h0000_0010; be[2] = 4'h3;
    #1;
    chk("par_gnt", {29'd0, gnt}, 32'h5);
    chk("par_sreq", {29'd0, sreq}, 32'h3);
    chk("par_swe", {29'd0, swe}, 32'h2);
    chk("par_swdata1", swdata[1], 32'h1234_5678);
    chk("par_sbe1", {28'd0, sbe[1]}, 32'hF);
    chk("par_sbe0", {28'd0, sbe[0]}, 32'h3);
    chk("par_idle_saddr2", saddr[2], 32'd0);
    step();
    req = '0; we = '0;
    #1;
    chk("par_rvalid", {29'd0, rvalid}, 32'h5);
    chk("par_rdata0", rdata[0], 32'hCAFE_0001);
    chk("par_rdata2", rdata[2], 32'hDEAD_BEEF);
    step();

    // Contention on slave 1 (slave 1 last granted master 0)
`ifdef OBI_RR_ARB_EN
    exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b001;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
`endif
    for (int i = 0; i < 3; i++) addr[i] = 32'h1000_0008;
    req = 3'b111;
    #1;
    chk("con_gnt0", {29'd0, gnt}, {29'd0, exp_g[0]});
    chk("con_sreq", {29'd0, sreq}, 32'h2);
    step();
    req = req & ~exp_g[0];
    #1;
    chk("con_rv0", {29'd0, rvalid}, {29'd0, exp_g[0]});
    chk("con_gnt1", {29'd0, gnt}, {29'd0, exp_g[1]});
    step();
    req = req & ~exp_g[1];
    #1;
    chk("con_rv1", {29'd0, rvalid}, {29'd0, exp_g[1]});
    chk("con_gnt2", {29'd0, gnt}, {29'd0, exp_g[2]});
    step();
    req = '0;
    #1;
    chk("con_rv2", {29'd0, rvalid}, {29'd0, exp_g[2]});
    chk("con_rdata1", rdata[1], (exp_g[2] == 3'b010) ? 32'hCAFE_0001 : 32'd0);
    step();

    // Unmapped read from master 1
    req = 3'b010; addr[1] = 32'h7000_0000;
    #1;
    chk("um_gnt", {29'd0, gnt}, 32'h2);
    chk("um_sreq", {29'd0, sreq}, 32'd0);
    step();
    req = '0;
    #1;
    chk("um_rvalid", {29'd0, rvalid}, 32'h2);
    chk("um_rdata1", rdata[1], 32'd0);
    step();

    // Reset asserted the cycle after grant drops the response
    req = 3'b100; addr[2] = 32'h0000_0010;
    #1;
    chk("rm_gnt", {29'd0, gnt}, 32'h4);
    step();
    req = '0; rst = 1'b1;
    #1;
    chk("rm_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rm_rdata2", rdata[2], 32'd0);
    req = 3'b001; addr[0] = 32'h0000_0010;
    #1;
    chk("rm_comb_gnt", {29'd0, gnt}, 32'h1);
    step();
    chk("rm_hold_rvalid", {29'd0, rvalid}, 32'd0);
    req = '0;
    #3 rst = 1'b0;
    step();
    req = 3'b100; addr[2] = 32'h0000_0010;
    step();
    req = '0;
    #1;
    chk("rm_after_rvalid", {29'd0, rvalid}, 32'h4);
    chk("rm_after_rdata2", rdata[2], 32'hDEAD_BEEF);
    step();

    // Overlapping decode: lowest slave index wins
    req = 3'b001; addr[0] = 32'h1000_0020;
    #1;
    chk("ov_sreq", {29'd0, sreq}, 32'h2);
    chk("ov_saddr1", saddr[1], 32'h1000_0020);
    chk("ov_saddr2", saddr[2], 32'd0);
    step();
    req = '0;
    #1;
    chk("ov_rdata0", rdata[0], 32'hCAFE_0001);
    step();

    // Back-to-back: master 0 reads slave 0 then slave 1
    req = 3'b001; addr[0] = 32'h0000_0010;
    step();
    addr[0] = 32'h1000_0000;
    #1;
    chk("b2b_gnt", {29'd0, gnt}, 32'h1);
    chk("b2b_rdata_a", rdata[0], 32'hDEAD_BEEF);
    step();
    req = '0;
    #1;
    chk("b2b_rvalid_b", {29'd0, rvalid}, 32'h1);
    chk("b2b_rdata_b", rdata[0], 32'hCAFE_0001);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
